// File: rtl/hazard_forward_unit.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_forward_unit
//  Description : Operand-forwarding select and load-use stall generator for
//                the 5-stage core. Optional statistics counters are built
//                when FWD_STATS_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_forward_unit #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      id_valid,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
    input  logic                      id_rs1_used,
    input  logic                      id_rs2_used,
    input  logic [REG_ADDR_WIDTH-1:0] id_rd,
    input  logic                      id_reg_write,
    input  logic                      id_mem_read,
    input  logic                      ex_flush,
    output logic                      stall,
    output logic [1:0]                forwardA,
    output logic [1:0]                forwardB
`ifdef FWD_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0]      stat_stalls,
    output logic [CNT_WIDTH-1:0]      stat_fwd_ex,
    output logic [CNT_WIDTH-1:0]      stat_fwd_wb
`endif
);

    localparam logic [1:0]                c_sel_rf    = 2'b00;
    localparam logic [1:0]                c_sel_memwb = 2'b01;
    localparam logic [1:0]                c_sel_exmem = 2'b10;
    localparam logic [REG_ADDR_WIDTH-1:0] c_reg_zero  = '0;

    // The register file is write-first, so a producer in WB never needs a
    // forward path; only the EX and MEM shadow stages are materialised.
    logic                      r_ex_valid;
    logic [REG_ADDR_WIDTH-1:0] r_ex_rd;
    logic                      r_ex_reg_write;
    logic                      r_ex_mem_read;
    logic                      r_mem_valid;
    logic [REG_ADDR_WIDTH-1:0] r_mem_rd;
    logic                      r_mem_reg_write;
    logic [1:0]                r_forward_a;
    logic [1:0]                r_forward_b;

    logic                      w_ex_live;
    logic                      w_mem_live;
    logic                      w_ex_load;
    logic                      w_stall;
    logic                      w_id_enter;
    logic [1:0]                w_fa_next;
    logic [1:0]                w_fb_next;

    function automatic logic [1:0] sel_for(
        input logic [REG_ADDR_WIDTH-1:0] rs,
        input logic                      used,
        input logic                      ex_live,
        input logic [REG_ADDR_WIDTH-1:0] ex_rd,
        input logic                      mem_live,
        input logic [REG_ADDR_WIDTH-1:0] mem_rd
    );
        logic [1:0] sel;
        sel = c_sel_rf;
        if (used && ex_live && (rs == ex_rd)) begin
            sel = c_sel_exmem;
        end else if (used && mem_live && (rs == mem_rd)) begin
            sel = c_sel_memwb;
        end
        return sel;
    endfunction

    always_comb begin
        w_ex_live  = r_ex_valid  & r_ex_reg_write  & (r_ex_rd  != c_reg_zero);
        w_mem_live = r_mem_valid & r_mem_reg_write & (r_mem_rd != c_reg_zero);
        w_ex_load  = r_ex_valid  & r_ex_mem_read   & (r_ex_rd  != c_reg_zero);
        // Flush and reset both dominate the load-use stall.
        w_stall    = ~rst & id_valid & ~ex_flush & w_ex_load &
                     ((id_rs1_used & (id_rs1 == r_ex_rd)) |
                      (id_rs2_used & (id_rs2 == r_ex_rd)));
        w_id_enter = id_valid & ~w_stall & ~ex_flush;
        w_fa_next  = sel_for(id_rs1, id_rs1_used, w_ex_live, r_ex_rd, w_mem_live, r_mem_rd);
        w_fb_next  = sel_for(id_rs2, id_rs2_used, w_ex_live, r_ex_rd, w_mem_live, r_mem_rd);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex_valid      <= 1'b0;
            r_ex_rd         <= '0;
            r_ex_reg_write  <= 1'b0;
            r_ex_mem_read   <= 1'b0;
            r_mem_valid     <= 1'b0;
            r_mem_rd        <= '0;
            r_mem_reg_write <= 1'b0;
            r_forward_a     <= c_sel_rf;
            r_forward_b     <= c_sel_rf;
        end else begin
            r_mem_valid     <= r_ex_valid;
            r_mem_rd        <= r_ex_rd;
            r_mem_reg_write <= r_ex_reg_write;
            if (w_id_enter) begin
                r_ex_valid     <= 1'b1;
                r_ex_rd        <= id_rd;
                r_ex_reg_write <= id_reg_write;
                r_ex_mem_read  <= id_mem_read;
                r_forward_a    <= w_fa_next;
                r_forward_b    <= w_fb_next;
            end else begin
                r_ex_valid     <= 1'b0;
                r_ex_rd        <= '0;
                r_ex_reg_write <= 1'b0;
                r_ex_mem_read  <= 1'b0;
                r_forward_a    <= c_sel_rf;
                r_forward_b    <= c_sel_rf;
            end
        end
    end

    assign stall    = w_stall;
    assign forwardA = r_forward_a;
    assign forwardB = r_forward_b;

`ifdef FWD_STATS_EN
    localparam logic [CNT_WIDTH-1:0] c_cnt_one = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] c_cnt_max = '1;

    logic [CNT_WIDTH-1:0] r_stat_stalls;
    logic [CNT_WIDTH-1:0] r_stat_fwd_ex;
    logic [CNT_WIDTH-1:0] r_stat_fwd_wb;
    logic                 w_any_ex;
    logic                 w_any_wb;

    // A cycle where both operands share a code counts once.
    assign w_any_ex = (r_forward_a == c_sel_exmem) | (r_forward_b == c_sel_exmem);
    assign w_any_wb = (r_forward_a == c_sel_memwb) | (r_forward_b == c_sel_memwb);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_stalls <= '0;
            r_stat_fwd_ex <= '0;
            r_stat_fwd_wb <= '0;
        end else begin
            if (w_stall && (r_stat_stalls != c_cnt_max)) begin
                r_stat_stalls <= r_stat_stalls + c_cnt_one;
            end
            if (w_any_ex && (r_stat_fwd_ex != c_cnt_max)) begin
                r_stat_fwd_ex <= r_stat_fwd_ex + c_cnt_one;
            end
            if (w_any_wb && (r_stat_fwd_wb != c_cnt_max)) begin
                r_stat_fwd_wb <= r_stat_fwd_wb + c_cnt_one;
            end
        end
    end

    assign stat_stalls = r_stat_stalls;
    assign stat_fwd_ex = r_stat_fwd_ex;
    assign stat_fwd_wb = r_stat_fwd_wb;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_forward_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_forward_unit
//  Description : Scoreboard bench for hazard_forward_unit: directed pipeline
//                scenarios followed by randomized instruction streams.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_forward_unit;

    logic       clk;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_rs1_used;
    logic       id_rs2_used;
    logic [4:0] id_rd;
    logic       id_reg_write;
    logic       id_mem_read;
    logic       ex_flush;
    logic       stall;
    logic [1:0] forwardA;
    logic [1:0] forwardB;
`ifdef FWD_STATS_EN
    logic [31:0] stat_stalls;
    logic [31:0] stat_fwd_ex;
    logic [31:0] stat_fwd_wb;
`endif

    hazard_forward_unit #(.REG_ADDR_WIDTH(5), .CNT_WIDTH(32)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_rs1_used  (id_rs1_used),
        .id_rs2_used  (id_rs2_used),
        .id_rd        (id_rd),
        .id_reg_write (id_reg_write),
        .id_mem_read  (id_mem_read),
        .ex_flush     (ex_flush),
        .stall        (stall),
        .forwardA     (forwardA),
        .forwardB     (forwardB)
`ifdef FWD_STATS_EN
        ,
        .stat_stalls  (stat_stalls),
        .stat_fwd_ex  (stat_fwd_ex),
        .stat_fwd_wb  (stat_fwd_wb)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       v;
        logic [4:0] rd;
        logic       rw;
        logic       mr;
    } instr_t;

    typedef struct packed {
        logic       stall;
        logic [1:0] fa;
        logic [1:0] fb;
    } exp_t;

    // Reference pipeline: pipe[0] = instruction now in EX, pipe[1] = MEM, pipe[2] = WB.
    instr_t pipe[3];
    logic [1:0] m_fa;
    logic [1:0] m_fb;
    int unsigned m_stalls;
    int unsigned m_ex;
    int unsigned m_wb;
    exp_t sb_q[$];
    int checks;
    int failures;

    // Youngest in-flight writer of rs decides the source; age 0 is EX/MEM next cycle.
    function automatic logic [1:0] ref_sel(input logic [4:0] rs, input logic used);
        if (!used || rs == 5'd0) return 2'b00;
        for (int age = 0; age < 2; age++) begin
            if (pipe[age].v && pipe[age].rw && pipe[age].rd == rs)
                return (age == 0) ? 2'b10 : 2'b01;
        end
        return 2'b00;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic cyc(input logic v, input logic [4:0] d, input logic w, input logic mr,
                       input logic [4:0] r1, input logic u1, input logic [4:0] r2, input logic u2,
                       input logic fl, input logic rs);
        logic   e_stall;
        logic   enter;
        instr_t ni;
        id_valid = v; id_rd = d; id_reg_write = w; id_mem_read = mr;
        id_rs1 = r1; id_rs1_used = u1; id_rs2 = r2; id_rs2_used = u2;
        ex_flush = fl; rst = rs;
        e_stall = !rs && v && !fl && pipe[0].v && pipe[0].mr && pipe[0].rd != 5'd0 &&
                  ((u1 && r1 == pipe[0].rd) || (u2 && r2 == pipe[0].rd));
        sb_q.push_back('{stall: e_stall, fa: m_fa, fb: m_fb});
        if (rs) begin
            for (int i = 0; i < 3; i++) pipe[i] = '0;
            m_fa = 2'b00; m_fb = 2'b00;
            m_stalls = 0; m_ex = 0; m_wb = 0;
        end else begin
            if (e_stall) m_stalls++;
            if (m_fa == 2'b10 || m_fb == 2'b10) m_ex++;
            if (m_fa == 2'b01 || m_fb == 2'b01) m_wb++;
            enter = v && !e_stall && !fl;
            m_fa = enter ? ref_sel(r1, u1) : 2'b00;
            m_fb = enter ? ref_sel(r2, u2) : 2'b00;
            ni = enter ? '{v: 1'b1, rd: d, rw: w, mr: mr} : '0;
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = ni;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic alu(input logic [4:0] d, input logic [4:0] r1, input logic [4:0] r2);
        cyc(1'b1, d, 1'b1, 1'b0, r1, 1'b1, r2, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic ld(input logic [4:0] d, input logic [4:0] r1);
        cyc(1'b1, d, 1'b1, 1'b1, r1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic nop(input int n);
        for (int i = 0; i < n; i++)
            cyc(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: outputs are presented every cycle and compared away from the edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                checks++;
                if ({stall, forwardA, forwardB} !== {e.stall, e.fa, e.fb}) begin
                    failures++;
                    $display("FAIL sel_stall t=%0t got stall=%0b fA=%b fB=%b expected stall=%0b fA=%b fB=%b",
                             $time, stall, forwardA, forwardB, e.stall, e.fa, e.fb);
                end
            end
        end
    end

    initial begin
        checks = 0; failures = 0;
        for (int i = 0; i < 3; i++) pipe[i] = '0;
        m_fa = 2'b00; m_fb = 2'b00;
        m_stalls = 0; m_ex = 0; m_wb = 0;
        rst = 1'b1; id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_rs1_used = 1'b0;
        id_rs2_used = 1'b0; id_rd = '0; id_reg_write = 1'b0; id_mem_read = 1'b0; ex_flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_stall", {31'd0, stall}, 32'd0);
        chk("reset_fwd", {28'd0, forwardA, forwardB}, 32'd0);
        cyc(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
`ifdef FWD_STATS_EN
        chk("reset_stat_stalls", stat_stalls, 32'd0);
        chk("reset_stat_fwd_ex", stat_fwd_ex, 32'd0);
        chk("reset_stat_fwd_wb", stat_fwd_wb, 32'd0);
`endif
        // 1: back-to-back ALU dependency
        alu(5'd5, 5'd1, 5'd2); alu(5'd6, 5'd5, 5'd1); nop(3);
        // 2: one-instruction gap, operand B from MEM/WB
        alu(5'd5, 5'd1, 5'd2); nop(1); alu(5'd7, 5'd2, 5'd5); nop(3);
        // 3: load-use, dependent instruction re-presented while stalled
        ld(5'd5, 5'd1); alu(5'd6, 5'd5, 5'd5); alu(5'd6, 5'd5, 5'd5); nop(3);
`ifdef FWD_STATS_EN
        chk("scen_stat_stalls", stat_stalls, 32'd1);
        chk("scen_stat_fwd_ex", stat_fwd_ex, 32'd1);
        chk("scen_stat_fwd_wb", stat_fwd_wb, 32'd2);
`endif
        // 4: x0 never forwards; youngest producer wins
        alu(5'd0, 5'd1, 5'd2); alu(5'd6, 5'd0, 5'd0); nop(3);
        alu(5'd5, 5'd1, 5'd2); alu(5'd5, 5'd3, 5'd4); alu(5'd6, 5'd5, 5'd0); nop(3);
        // 5: flush beats load-use stall
        ld(5'd5, 5'd1);
        cyc(1'b1, 5'd6, 1'b1, 1'b0, 5'd5, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0);
        nop(3);
        // 6: reset while a load-use stall is active
        ld(5'd5, 5'd1); alu(5'd6, 5'd5, 5'd5);
        cyc(1'b1, 5'd6, 1'b1, 1'b0, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1);
        alu(5'd6, 5'd5, 5'd5); nop(3);

        for (int n = 0; n < 3000; n++) begin
            cyc($urandom_range(0, 9) != 0, 5'($urandom_range(0, 7)), $urandom_range(0, 4) != 0,
                $urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
                5'($urandom_range(0, 7)), $urandom_range(0, 1) != 0,
                $urandom_range(0, 11) == 0, $urandom_range(0, 79) == 0);
        end
        nop(2);

        for (int k = 0; k < 20 && sb_q.size() > 0; k++) @(negedge clk);
        if (sb_q.size() > 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d expected=0 pending entries", sb_q.size());
        end
        #1;
`ifdef FWD_STATS_EN
        chk("final_stat_stalls", stat_stalls, m_stalls);
        chk("final_stat_fwd_ex", stat_fwd_ex, m_ex);
        chk("final_stat_fwd_wb", stat_fwd_wb, m_wb);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
